// File: rtl/if_id_buffer.sv
// Fetch-to-decode pipeline register: splits the 64-bit fetch bundle into decode fields and
// joins an opcode word and the immediate word that follows it into one decode instruction.
module if_id_buffer #(
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [63:0] In,
    input  logic        Stall,
    input  logic        Flush,
    output logic        Out_Valid,
    output logic [15:0] Out_Instr,
    output logic [15:0] Out_Imm,
    output logic [31:0] Out_PC,
    output logic [15:0] Out_Side,
    output logic        dbg_state
);

    typedef enum logic {
        WORD0 = 1'b0,
        WORD1 = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] hold_instr, hold_instr_nxt;
    logic [15:0] hold_side, hold_side_nxt;
    logic        valid_nxt;
    logic [15:0] instr_nxt, imm_nxt, side_nxt;
    logic [31:0] pc_nxt;

    // Out_Valid qualifies Out_* on every cycle. There is no ready input: decode
    // cannot refuse a word, and back-pressure arrives only through Stall.
    assign dbg_state = state;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= WORD0;
            hold_instr <= 16'h0000;
            hold_side  <= 16'h0000;
            Out_Valid  <= 1'b0;
            Out_Instr  <= NOP_WORD;
            Out_Imm    <= 16'h0000;
            Out_PC     <= 32'h0000_0000;
            Out_Side   <= 16'h0000;
        end else begin
            state      <= state_nxt;
            hold_instr <= hold_instr_nxt;
            hold_side  <= hold_side_nxt;
            Out_Valid  <= valid_nxt;
            Out_Instr  <= instr_nxt;
            Out_Imm    <= imm_nxt;
            Out_PC     <= pc_nxt;
            Out_Side   <= side_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        hold_instr_nxt = hold_instr;
        hold_side_nxt  = hold_side;
        valid_nxt      = Out_Valid;
        instr_nxt      = Out_Instr;
        imm_nxt        = Out_Imm;
        pc_nxt         = Out_PC;
        side_nxt       = Out_Side;

        if (Flush) begin
            state_nxt      = WORD0;
            hold_instr_nxt = 16'h0000;
            hold_side_nxt  = 16'h0000;
            valid_nxt      = 1'b0;
            instr_nxt      = NOP_WORD;
            imm_nxt        = 16'h0000;
            pc_nxt         = 32'h0000_0000;
            side_nxt       = 16'h0000;
        end else if (!Stall) begin
            case (state)
                WORD0: begin
                    if (In[15]) begin
                        // Opcode of a two-word instruction: park it and emit a bubble.
                        state_nxt      = WORD1;
                        hold_instr_nxt = In[15:0];
                        hold_side_nxt  = In[63:48];
                        valid_nxt      = 1'b0;
                        instr_nxt      = NOP_WORD;
                        imm_nxt        = 16'h0000;
                        pc_nxt         = 32'h0000_0000;
                        side_nxt       = 16'h0000;
                    end else begin
                        valid_nxt = 1'b1;
                        instr_nxt = In[15:0];
                        imm_nxt   = 16'h0000;
                        pc_nxt    = In[47:16];
                        side_nxt  = In[63:48];
                    end
                end
                WORD1: begin
                    // Bit 15 here belongs to the immediate and is never decoded.
                    state_nxt = WORD0;
                    valid_nxt = 1'b1;
                    instr_nxt = hold_instr;
                    imm_nxt   = In[15:0];
                    pc_nxt    = In[47:16];
                    side_nxt  = hold_side;
                end
                default: state_nxt = WORD0;
            endcase
        end
    end

endmodule

// File: tb/tb_if_id_buffer.sv
// Bench for if_id_buffer: a reference model pushes expected outputs per driven cycle,
// which are popped and compared after the edge; directed plan cases then random traffic.
module tb_if_id_buffer;

    logic        Clk;
    logic        Rst;
    logic [63:0] In;
    logic        Stall;
    logic        Flush;
    logic        Out_Valid;
    logic [15:0] Out_Instr;
    logic [15:0] Out_Imm;
    logic [31:0] Out_PC;
    logic [15:0] Out_Side;
    logic        dbg_state;

    localparam logic [80:0] BUBBLE = {1'b0, 16'h0000, 16'h0000, 32'd0, 16'h0000};

    int n_checks = 0;
    int n_errors = 0;

    logic [80:0] exp_q[$];
    logic [80:0] out_bus;

    // reference model state
    logic        m_state;
    logic [15:0] m_hold_instr;
    logic [15:0] m_hold_side;
    logic [80:0] m_out;

    if_id_buffer #(.NOP_WORD(16'h0000)) dut (
        .Clk(Clk), .Rst(Rst), .In(In), .Stall(Stall), .Flush(Flush),
        .Out_Valid(Out_Valid), .Out_Instr(Out_Instr), .Out_Imm(Out_Imm),
        .Out_PC(Out_PC), .Out_Side(Out_Side), .dbg_state(dbg_state)
    );

    assign out_bus = {Out_Valid, Out_Instr, Out_Imm, Out_PC, Out_Side};

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [80:0] got, input logic [80:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state      = 1'b0;
        m_hold_instr = 16'h0000;
        m_hold_side  = 16'h0000;
        m_out        = BUBBLE;
    endtask

    task automatic model_step(input logic [63:0] in_v, input logic st, input logic fl);
        if (fl) begin
            m_state      = 1'b0;
            m_hold_instr = 16'h0000;
            m_hold_side  = 16'h0000;
            m_out        = BUBBLE;
        end else if (!st) begin
            if (!m_state) begin
                if (in_v[15]) begin
                    m_state      = 1'b1;
                    m_hold_instr = in_v[15:0];
                    m_hold_side  = in_v[63:48];
                    m_out        = BUBBLE;
                end else begin
                    m_out = {1'b1, in_v[15:0], 16'h0000, in_v[47:16], in_v[63:48]};
                end
            end else begin
                m_state = 1'b0;
                m_out   = {1'b1, m_hold_instr, in_v[15:0], in_v[47:16], m_hold_side};
            end
        end
    endtask

    // driver: one clock cycle of stimulus, scoreboard push before the edge, pop after it
    task automatic drive(input string tag, input logic [63:0] in_v, input logic st, input logic fl);
        logic [80:0] exp;
        In    = in_v;
        Stall = st;
        Flush = fl;
        model_step(in_v, st, fl);
        exp_q.push_back(m_out);
        @(posedge Clk);
        #1;
        exp = exp_q.pop_front();
        check(tag, out_bus, exp);
        check({tag, "_state"}, {80'd0, dbg_state}, {80'd0, m_state});
    endtask

    // asynchronous reset pulse placed between edges
    task automatic pulse_reset(input string tag);
        @(negedge Clk);
        #2;
        Rst = 1'b1;
        model_reset();
        #1;
        check({tag, "_imm"}, out_bus, BUBBLE);
        @(posedge Clk);
        #1;
        check({tag, "_hold"}, out_bus, BUBBLE);
        check({tag, "_state"}, {80'd0, dbg_state}, 81'd0);
        Rst = 1'b0;
    endtask

    initial begin
        Rst   = 1'b0;
        In    = 64'd0;
        Stall = 1'b0;
        Flush = 1'b0;
        model_reset();
        #3;
        Rst = 1'b1;
        #10;
        check("reset_state", out_bus, BUBBLE);
        @(negedge Clk);
        Rst = 1'b0;

        // load something non-zero, then reset between edges
        drive("pre_rst", {16'h5555, 32'd99, 16'h0ABC}, 1'b0, 1'b0);
        pulse_reset("rst_mid");

        // single-word streaming
        drive("single_a", {16'hAAAA, 32'd5, 16'h1234}, 1'b0, 1'b0);
        check("single_a_const", out_bus, {1'b1, 16'h1234, 16'h0000, 32'd5, 16'hAAAA});
        drive("single_b", {16'hBBBB, 32'd6, 16'h2345}, 1'b0, 1'b0);
        check("single_b_const", out_bus, {1'b1, 16'h2345, 16'h0000, 32'd6, 16'hBBBB});

        // two-word assembly; immediate has bit 15 set
        drive("two_op", {16'h00C1, 32'd10, 16'h8A00}, 1'b0, 1'b0);
        check("two_op_const", out_bus, BUBBLE);
        drive("two_imm", {16'h00C2, 32'd11, 16'hFFFF}, 1'b0, 1'b0);
        check("two_imm_const", out_bus, {1'b1, 16'h8A00, 16'hFFFF, 32'd11, 16'h00C1});
        drive("after_two", {16'h00C3, 32'd12, 16'h0101}, 1'b0, 1'b0);
        check("after_two_const", out_bus, {1'b1, 16'h0101, 16'h0000, 32'd12, 16'h00C3});

        // stall inside assembly
        drive("stl_op", {16'h0D0D, 32'd20, 16'h8A00}, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive("stl_hold", {16'h7777, 32'($urandom), 16'($urandom)}, 1'b1, 1'b0);
            check("stl_frozen", out_bus, BUBBLE);
        end
        drive("stl_imm", {16'h0E0E, 32'd21, 16'h0042}, 1'b0, 1'b0);
        check("stl_imm_const", out_bus, {1'b1, 16'h8A00, 16'h0042, 32'd21, 16'h0D0D});

        // stall on a valid output holds it
        drive("stl_valid", {16'h1111, 32'd40, 16'h8888}, 1'b1, 1'b0);
        check("stl_valid_const", out_bus, {1'b1, 16'h8A00, 16'h0042, 32'd21, 16'h0D0D});

        // flush + stall in WORD1
        drive("fl_op", {16'h0F0F, 32'd29, 16'h9000}, 1'b0, 1'b0);
        drive("fl_both", {16'h1212, 32'd99, 16'h0055}, 1'b1, 1'b1);
        check("fl_both_const", out_bus, BUBBLE);
        drive("fl_next", {16'h1313, 32'd30, 16'h0007}, 1'b0, 1'b0);
        check("fl_next_const", out_bus, {1'b1, 16'h0007, 16'h0000, 32'd30, 16'h1313});

        // reset mid-assembly
        drive("rst_op", {16'h1414, 32'd50, 16'h8A00}, 1'b0, 1'b0);
        pulse_reset("rst_w1");
        drive("rst_next", {16'h1515, 32'd51, 16'h0011}, 1'b0, 1'b0);
        check("rst_next_const", out_bus, {1'b1, 16'h0011, 16'h0000, 32'd51, 16'h1515});

        // random traffic
        for (int i = 0; i < 300; i++) begin
            drive("rand", {16'($urandom), 32'($urandom), 16'($urandom)},
                  1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) == 0));
        end

        if (exp_q.size() != 0) check("queue_empty", 81'(exp_q.size()), 81'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Pipeline register between the fetch stage and the decode stage. It captures the 64-bit fetch bundle each cycle and presents it to decode as separate registered fields. It assembles two-word instructions (opcode word plus 16-bit immediate word fetched on consecutive cycles) into one decode-stage instruction. It supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface

Parameters:
- NOP_WORD, 16'h0000, instruction encoding driven on Out_Instr for a bubble.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  asynchronous, active-high reset.
- In  input  64  fetch bundle:
  - [63:48] side-band field forwarded unchanged.
  - [47:16] PC+1 of the fetched word.
  - [15:0] fetched instruction word.
- Stall  input  1  hold all state and outputs this cycle; In is ignored.
- Flush  input  1  discard buffered and incoming content; insert a bubble. Has priority over Stall.
- Out_Valid  output  1  registered; 1 = Out_* carries a real instruction.
- Out_Instr  output  16  registered instruction (opcode) word.
- Out_Imm  output  16  registered immediate; 0 for single-word instructions.
- Out_PC  output  32  registered PC+1 of the last word of the instruction.
- Out_Side  output  16  registered side-band field of the first word of the instruction.

## Operation

- Word classification: in state WORD0, In[15]=1 marks the first word of a two-word instruction; In[15]=0 marks a single-word instruction.
- State machine states: WORD0 (expecting an opcode word) and WORD1 (expecting an immediate word).
- Internal holding registers: Hold_Instr (16), Hold_Side (16).
- Per rising edge, priority Flush > Stall > normal:
  - Flush=1:
    - Out_Valid=0, Out_Instr=NOP_WORD, Out_Imm=0, Out_PC=0, Out_Side=0.
    - State goes to WORD0; Hold_* cleared.
    - Applies equally mid-assembly in WORD1: the partial instruction is dropped.
  - Stall=1, Flush=0: state, Hold_* and all Out_* keep their values.
  - WORD0, In[15]=0:
    - Out_Valid=1, Out_Instr=In[15:0], Out_Imm=0, Out_PC=In[47:16], Out_Side=In[63:48].
    - State stays WORD0.
  - WORD0, In[15]=1:
    - Hold_Instr=In[15:0], Hold_Side=In[63:48].
    - Outputs load a bubble (Out_Valid=0, NOP_WORD, zeros).
    - State goes to WORD1.
  - WORD1:
    - Out_Valid=1, Out_Instr=Hold_Instr, Out_Imm=In[15:0], Out_PC=In[47:16], Out_Side=Hold_Side.
    - In[15] is data here and is not interpreted.
    - State goes to WORD0.
- No arithmetic is done in this block; all fields are copied bit-exact.

## Timing

- Reset (asynchronous, takes effect immediately, independent of Clk):
  - Out_Valid=0, Out_Instr=NOP_WORD, Out_Imm=0, Out_PC=0, Out_Side=0.
  - State=WORD0, Hold_*=0.
  - Reset asserted mid-assembly (WORD1) discards the held word.
- Single-word instruction: present on In at edge N, visible on Out_* after edge N (latency 1).
- Two-word instruction: opcode word at edge N produces a bubble after N. Immediate word at the next non-stalled edge M produces the full instruction after M.
- Stall cycles between the two words are allowed; the held word survives any number of stalls.
- Flush and Stall asserted together: flush wins.
- Outputs change only on a Clk rising edge or on Rst assertion. There is no combinational path from In, Stall or Flush to Out_*.

## Test plan

- Reset: assert Rst between edges.
  - Required: all Out_* go to zero / NOP_WORD immediately, and stay there while Rst=1.
- Single-word streaming: In = {16'hAAAA, 32'd5, 16'h1234}, then {16'hBBBB, 32'd6, 16'h2345}.
  - Required: Out_Valid=1 with Instr=1234, PC=5, Side=AAAA; next cycle Instr=2345, PC=6, Side=BBBB; Out_Imm=0 both cycles.
- Two-word assembly: In = {16'h00C1, 32'd10, 16'h8A00}, then {16'h00C2, 32'd11, 16'hFFFF}.
  - Required: first cycle Out_Valid=0 with NOP.
  - Required: next cycle Out_Valid=1, Instr=8A00, Imm=FFFF, PC=11, Side=00C1.
  - Bit 15 of the immediate word must not start a new assembly.
- Stall inside assembly: opcode word 8A00, then Stall=1 for 3 cycles while In changes, then immediate 0042 at PC 21.
  - Required: outputs frozen during the stall cycles; then Instr=8A00, Imm=0042, PC=21.
- Flush priority: in WORD1, assert Flush=1 and Stall=1 together.
  - Required: bubble output, state back to WORD0.
  - Required: the next word 0x0007 at PC 30 is decoded as a single-word instruction (Instr=0007, PC=30).
- Reset mid-assembly: opcode word 8A00, then Rst pulse, then word 0x0011.
  - Required: 0011 emitted as a single-word instruction with Out_Imm=0.
